// File: rtl/anim_pkg.sv
// Shared types and helpers for the 7-segment animation sequencer.
package anim_pkg;

   localparam int ANI_W           = 6;
   localparam int FRAME_W         = 5;
   localparam int NUM_ANI_DEFAULT = 51;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      SWITCH
   } state_t;

   // A zero length encodes the full 32-frame animation.
   function automatic logic [ANI_W-1:0] eff_limit(
      input logic [FRAME_W-1:0] limit
   );
      return (limit == '0) ? ANI_W'(32) : {1'b0, limit};
   endfunction

endpackage

// File: rtl/animation_sequencer_tick_gen.sv
// Frame prescaler: one tick every CLK_DIV enabled cycles.
module frame_tick_gen #(
   parameter int CLK_DIV = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && !clr && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/animation_sequencer.sv
// Animation selection, frame pacing and loop-based auto-advance
// for the 7-segment animation engine.
module animation_sequencer
   import anim_pkg::*;
#(
   parameter int CLK_DIV       = 1000000,
   parameter int NUM_ANI       = NUM_ANI_DEFAULT,
   parameter int LOOPS_PER_ANI = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena,
   input  logic               btn_next,
   input  logic               btn_prev,
   input  logic               sel_load,
   input  logic [ANI_W-1:0]   sel_value,
   input  logic               auto_mode,
   input  logic [FRAME_W-1:0] limit,
   output logic [ANI_W-1:0]   animation,
   output logic [FRAME_W-1:0] frame,
   output logic               frame_tick,
   output logic               anim_changed
);

   localparam int LW = (LOOPS_PER_ANI > 1) ? $clog2(LOOPS_PER_ANI) : 1;
   localparam logic [LW-1:0]    LOOP_LAST = LW'(LOOPS_PER_ANI - 1);
   localparam logic [ANI_W-1:0] ANI_LAST  = ANI_W'(NUM_ANI - 1);

   state_t state, state_nx;

   logic               next_q, prev_q;
   logic               next_ev, prev_ev;
   logic [LW-1:0]      loop_cnt;
   logic               run_en, tick;
   logic [ANI_W-1:0]   eff;
   logic [FRAME_W:0]   frame_inc;
   logic               wrap, loop_done, auto_ev, sel_ev;
   logic [ANI_W-1:0]   ani_up, ani_dn, ani_nx;

   assign run_en    = (state == RUN) && ena;
   assign eff       = eff_limit(limit);
   assign frame_inc = {1'b0, frame} + 1'b1;
   // >= rather than == so a stale frame past the limit still wraps
   assign wrap      = frame_inc >= eff;
   assign loop_done = tick && wrap && (loop_cnt == LOOP_LAST);
   assign auto_ev   = auto_mode && loop_done;
   assign next_ev   = btn_next && !next_q;
   assign prev_ev   = btn_prev && !prev_q;
   assign ani_up    = (animation == ANI_LAST) ? '0 : animation + 1'b1;
   assign ani_dn    = (animation == '0) ? ANI_LAST : animation - 1'b1;

   frame_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (!run_en),
      .en   (run_en),
      .tick (tick)
   );

   always_comb begin
      state_nx = state;
      sel_ev   = 1'b0;
      ani_nx   = animation;
      if (state != SWITCH) begin
         if (sel_load) begin
            sel_ev = 1'b1;
            ani_nx = ({1'b0, sel_value} < 7'(NUM_ANI)) ? sel_value : '0;
         end else if (next_ev ^ prev_ev) begin
            sel_ev = 1'b1;
            ani_nx = next_ev ? ani_up : ani_dn;
         end else if (auto_ev) begin
            sel_ev = 1'b1;
            ani_nx = ani_up;
         end
      end
      unique case (state)
         IDLE:    if (ena) state_nx = RUN;
         RUN:     if (!ena) state_nx = IDLE;
         SWITCH:  state_nx = ena ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
      if (sel_ev)
         state_nx = SWITCH;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         next_q       <= 1'b0;
         prev_q       <= 1'b0;
         animation    <= '0;
         frame        <= '0;
         loop_cnt     <= '0;
         frame_tick   <= 1'b0;
         anim_changed <= 1'b0;
      end else begin
         next_q       <= btn_next;
         prev_q       <= btn_prev;
         animation    <= ani_nx;
         frame_tick   <= tick;
         anim_changed <= (state == SWITCH);
         if (state == SWITCH) begin
            frame    <= '0;
            loop_cnt <= '0;
         end else if (tick) begin
            frame <= wrap ? '0 : frame_inc[FRAME_W-1:0];
            if (wrap)
               loop_cnt <= loop_done ? '0 : loop_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_animation_sequencer.sv
// Randomized self-checking bench for animation_sequencer.
module tb_animation_sequencer;

   localparam int CLK_DIV = 4;
   localparam int NUM_ANI = 51;
   localparam int LOOPS   = 2;

   logic       clk;
   logic       rst;
   logic       ena;
   logic       btn_next;
   logic       btn_prev;
   logic       sel_load;
   logic [5:0] sel_value;
   logic       auto_mode;
   logic [4:0] limit;
   logic [5:0] animation;
   logic [4:0] frame;
   logic       frame_tick;
   logic       anim_changed;

   logic [4:0] len_tab [64];

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int m_pc, m_frame, m_anim, m_loops;
   bit m_run, m_sw, m_ft, m_ac, m_pn, m_pp;

   animation_sequencer #(
      .CLK_DIV       (CLK_DIV),
      .NUM_ANI       (NUM_ANI),
      .LOOPS_PER_ANI (LOOPS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .btn_next     (btn_next),
      .btn_prev     (btn_prev),
      .sel_load     (sel_load),
      .sel_value    (sel_value),
      .auto_mode    (auto_mode),
      .limit        (limit),
      .animation    (animation),
      .frame        (frame),
      .frame_tick   (frame_tick),
      .anim_changed (anim_changed)
   );

   assign limit = len_tab[animation];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_frame = 0; m_anim = 0; m_loops = 0;
      m_run = 0; m_sw = 0; m_ft = 0; m_ac = 0; m_pn = 0; m_pp = 0;
   endtask

   function automatic int eff_now();
      return (limit == 0) ? 32 : int'(limit);
   endfunction

   task automatic model_step();
      int  eff;
      bit  ne, pe, ev, adv;
      eff  = eff_now();
      ne   = btn_next && !m_pn;
      pe   = btn_prev && !m_pp;
      m_ac = m_sw;
      m_ft = 0;
      adv  = 0;
      ev   = 0;
      if (m_sw) begin
         m_frame = 0; m_pc = 0; m_loops = 0;
         m_sw = 0; m_run = ena;
      end else begin
         if (m_run && ena) begin
            if (m_pc == CLK_DIV - 1) begin
               m_pc = 0;
               m_ft = 1;
               if (m_frame + 1 >= eff) begin
                  m_frame = 0;
                  m_loops++;
                  if (m_loops == LOOPS) begin
                     m_loops = 0;
                     adv = auto_mode;
                  end
               end else begin
                  m_frame++;
               end
            end else begin
               m_pc++;
            end
         end else begin
            m_pc = 0;
         end
         if (sel_load) begin
            ev = 1;
            m_anim = (sel_value < NUM_ANI) ? int'(sel_value) : 0;
         end else if (ne != pe) begin
            ev = 1;
            m_anim = ne ? (m_anim + 1) % NUM_ANI
                        : (m_anim + NUM_ANI - 1) % NUM_ANI;
         end else if (adv) begin
            ev = 1;
            m_anim = (m_anim + 1) % NUM_ANI;
         end
         m_sw  = ev;
         m_run = ena;
      end
      m_pn = btn_next;
      m_pp = btn_prev;
   endtask

   function automatic bit auto_due();
      return !m_sw && m_run && ena && auto_mode && !sel_load
          && (m_pc == CLK_DIV - 1) && (m_frame + 1 >= eff_now())
          && (m_loops + 1 == LOOPS);
   endfunction

   task automatic cyc();
      model_step();
      @(posedge clk);
      #2;
      chk("animation", animation, m_anim);
      chk("frame", frame, m_frame);
      chk("frame_tick", frame_tick, m_ft);
      chk("anim_changed", anim_changed, m_ac);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic load(input int v);
      sel_load  = 1'b1;
      sel_value = 6'(v);
      cyc();
      sel_load  = 1'b0;
   endtask

   // called 2 time units after a rising edge
   task automatic async_reset();
      #1 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_animation", animation, 0);
      chk("rst_frame", frame, 0);
      chk("rst_frame_tick", frame_tick, 0);
      chk("rst_anim_changed", anim_changed, 0);
      #3 rst = 1'b0;
   endtask

   initial begin
      int cnt, maxf, prevf, saw, a0, f0, found;
      for (int i = 0; i < 64; i++) len_tab[i] = 5'($urandom_range(0, 31));
      len_tab[0]  = 5'd10;
      len_tab[1]  = 5'd0;
      len_tab[2]  = 5'd2;
      len_tab[7]  = 5'd3;
      len_tab[50] = 5'd5;

      rst = 1'b1; ena = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
      sel_load = 1'b0; sel_value = '0; auto_mode = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      chk("init_animation", animation, 0);
      chk("init_frame", frame, 0);
      chk("init_frame_tick", frame_tick, 0);
      chk("init_anim_changed", anim_changed, 0);
      rst = 1'b0;

      // limit 10: ten ticks per 40-cycle loop
      ena = 1'b1;
      run(5);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         cnt += int'(frame_tick);
      end
      chk("ticks_per_loop", cnt, 10);

      // limit 0 -> 32 frames
      load(1);
      chk("sel_direct", animation, 1);
      maxf = 0; saw = 0; prevf = 0;
      for (int i = 0; i < 140; i++) begin
         cyc();
         if (frame > maxf) maxf = frame;
         if (prevf == 31 && frame == 0) saw = 1;
         prevf = frame;
      end
      chk("max_frame32", maxf, 31);
      chk("wrap32", saw, 1);

      // next/prev wrap at the ends
      load(50);
      run(3);
      btn_next = 1'b1;
      cyc();
      chk("next_wrap", animation, 0);
      cyc();
      chk("next_changed", anim_changed, 1);
      chk("next_frame_clr", frame, 0);
      btn_next = 1'b0;
      run(2);
      btn_prev = 1'b1;
      cyc();
      chk("prev_wrap", animation, 50);
      run(6);
      chk("prev_held_once", animation, 50);
      btn_prev = 1'b0;
      run(2);

      load(55);
      chk("sel_out_of_range", animation, 0);
      run(3);
      load(7);
      chk("sel_seven", animation, 7);
      run(3);

      // auto advance with a coincident manual next
      load(2);
      auto_mode = 1'b1;
      run(70);
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         if (auto_due()) found = 1;
         else cyc();
      end
      chk("auto_found", found, 1);
      a0 = animation;
      btn_next = 1'b1;
      cyc();
      chk("auto_plus_next", animation, (a0 + 1) % NUM_ANI);
      btn_next = 1'b0;
      auto_mode = 1'b0;
      run(3);

      a0 = animation;
      btn_next = 1'b1;
      btn_prev = 1'b1;
      cyc();
      chk("both_edges", animation, a0);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      run(7);

      // freeze
      ena = 1'b0;
      run(2);
      f0 = frame;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         cnt += int'(frame_tick);
      end
      chk("idle_ticks", cnt, 0);
      chk("idle_frame", frame, f0);
      ena = 1'b1;
      run(10);

      async_reset();
      run(10);

      for (int i = 0; i < 3000; i++) begin
         ena = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
         if ($urandom_range(0, 7) == 0) btn_prev = ~btn_prev;
         sel_load  = ($urandom_range(0, 39) == 0);
         sel_value = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
         if ($urandom_range(0, 499) == 0) async_reset();
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
